// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encodings, frame
// geometry and the frame bit lookup used by the serializer.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_e;

    localparam int UART_FRAME_BITS      = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 44;

    // Line level for frame position idx: start bit, eight data bits LSB first, stop bit.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        logic bit_v;
        if (idx == 4'd0) begin
            bit_v = 1'b0;
        end else if (idx <= 4'd8) begin
            bit_v = data[3'(idx - 4'd1)];
        end else begin
            bit_v = 1'b1;
        end
        return bit_v;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: one frame per accepted start, start ignored while a frame
// is active. data must be held stable by the caller for the whole frame.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_LAST  = 4'(UART_FRAME_BITS - 1);

    logic              r_active;
    logic [BAUD_W-1:0] r_baud;
    logic [3:0]        r_bit;
    logic              r_txd;

    // Baud and bit counters; txd is registered so the start bit appears on the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_txd    <= 1'b1;
        end else if (!r_active) begin
            if (start) begin
                r_active <= 1'b1;
                r_baud   <= '0;
                r_bit    <= 4'd0;
                r_txd    <= 1'b0;
            end else begin
                r_txd    <= 1'b1;
            end
        end else if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == BIT_LAST) begin
                r_active <= 1'b0;
                r_bit    <= 4'd0;
                r_txd    <= 1'b1;
            end else begin
                r_bit    <= r_bit + 4'd1;
                r_txd    <= frame_bit(data, r_bit + 4'd1);
            end
        end else begin
            r_baud <= r_baud + BAUD_W'(1);
        end
    end

    assign txd  = r_txd;
    assign done = r_active && (r_bit == BIT_LAST) && (r_baud == BAUD_LAST);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmit line between NUM_REQ byte
// requesters; one byte per grant, serialized 8N1.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy,
    output logic                 usb_rs232_txd
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_e       r_state;
    sched_state_e       w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] w_ack_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic [7:0]         r_data;
    logic [7:0]         w_data_nxt;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic               w_gnt_vld;
    logic               w_start;
    logic               w_done;
    logic               w_txd;

    // First requester at or after the priority pointer, wrapping modulo NUM_REQ.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        logic             v_hit;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        v_idx     = '0;
        v_hit     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx     = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            v_hit     = !w_gnt_vld && req[v_idx];
            w_gnt_idx = v_hit ? v_idx : w_gnt_idx;
            w_gnt_vld = w_gnt_vld || v_hit;
        end
    end

    // Next-state logic: grant in IDLE, wait for the serializer in SEND.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ack_nxt   = '0;
        w_busy_nxt  = r_busy;
        w_data_nxt  = r_data;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_start     = 1'b1;
                    w_ack_nxt   = NUM_REQ'(1) << w_gnt_idx;
                    w_data_nxt  = req_data[{w_gnt_idx, 3'b000} +: 8];
                    w_ptr_nxt   = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SEND;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            SEND: begin
                if (w_done) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer, ack pulse, busy flag and granted byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            r_data  <= w_data_nxt;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk  (clk),
        .rst  (rst),
        .start(w_start),
        .data (r_data),
        .txd  (w_txd),
        .done (w_done)
    );

    assign ack           = r_ack;
    assign busy          = r_busy;
    assign usb_rs232_txd = w_txd;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed scoreboard bench for uart_tx_scheduler: a fast instance
// (CLKS_PER_BIT=4) and a full-rate instance (CLKS_PER_BIT=44).
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req44;
    logic [31:0] req_data, req_data44;
    logic [3:0]  ack, ack44;
    logic        busy, busy44, txd, txd44;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(4), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .busy(busy), .usb_rs232_txd(txd)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .CLKS_PER_BIT(44)) dut44 (
        .clk(clk), .rst(rst), .req(req44), .req_data(req_data44),
        .ack(ack44), .busy(busy44), .usb_rs232_txd(txd44)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_ack(input bit s44, input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if ((s44 ? ack44 : ack) != 4'b0000) got = 1'b1;
        end
    endtask

    // Called on the negedge where the start bit first shows; ends on the idle cycle after the frame.
    task automatic check_frame(input bit s44, input logic [7:0] d, input int cpb);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int c = 0; c < 10 * cpb; c++) begin
            check("txd_bit", 32'(s44 ? txd44 : txd), 32'(fr[c / cpb]));
            check("busy_in_frame", 32'(s44 ? busy44 : busy), 32'd1);
            if (c > 0) check("no_ack_in_send", 32'(s44 ? ack44 : ack), 32'd0);
            @(negedge clk);
        end
        check("busy_after_frame", 32'(s44 ? busy44 : busy), 32'd0);
        check("txd_after_frame", 32'(s44 ? txd44 : txd), 32'd1);
    endtask

    task automatic serve(input bit s44, input int budget, input bit drop, input int cpb,
                         input logic [8:0] upd, input logic [3:0] raise);
        exp_t e;
        bit   got;
        wait_ack(s44, budget, got);
        check("ack_seen", 32'(got), 32'd1);
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{idx: 0, data: 8'h00};
        if (got) begin
            check("ack_onehot", 32'(s44 ? ack44 : ack), 32'(4'b0001 << e.idx));
            if (s44) begin
                req44 = req44 | raise;
                if (drop) req44[e.idx] = 1'b0;
                if (upd[8]) req_data44[8*e.idx +: 8] = upd[7:0];
            end else begin
                req = req | raise;
                if (drop) req[e.idx] = 1'b0;
                if (upd[8]) req_data[8*e.idx +: 8] = upd[7:0];
            end
            check_frame(s44, e.data, cpb);
        end
    endtask

    initial begin
        bit   got;
        exp_t e;
        rst = 1'b0; req = 4'b1111; req44 = 4'b0000;
        req_data = 32'h0; req_data44 = 32'h0;

        // Reset held with all requests asserted
        repeat (3) begin
            @(negedge clk);
            check("rst_txd", 32'(txd), 32'd1);
            check("rst_ack", 32'(ack), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        req = 4'b0000; rst = 1'b1;

        // Single request, requester 2
        @(negedge clk);
        req_data[23:16] = 8'hA5; req[2] = 1'b1;
        sb.push_back('{idx: 2, data: 8'hA5});
        serve(1'b0, 1, 1'b1, 4, 9'h000, 4'b0000);

        // Round robin from a freshly reset pointer
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_data[7:0] = 8'h3C; req_data[15:8] = 8'h81; req_data[31:24] = 8'hE7;
        req = 4'b1011;
        sb.push_back('{idx: 0, data: 8'h3C});
        sb.push_back('{idx: 1, data: 8'h81});
        sb.push_back('{idx: 3, data: 8'hE7});
        serve(1'b0, 1, 1'b1, 4, 9'h000, 4'b0000);
        serve(1'b0, 1, 1'b1, 4, 9'h000, 4'b0000);
        serve(1'b0, 1, 1'b1, 4, 9'h000, 4'b0000);
        req_data[7:0] = 8'h11; req_data[15:8] = 8'h22;
        req = 4'b0011;
        sb.push_back('{idx: 0, data: 8'h11});
        sb.push_back('{idx: 1, data: 8'h22});
        serve(1'b0, 1, 1'b1, 4, 9'h000, 4'b0000);
        serve(1'b0, 1, 1'b1, 4, 9'h000, 4'b0000);

        // Back-to-back on requester 1; data changed after the first ack
        req_data[15:8] = 8'h00; req[1] = 1'b1;
        sb.push_back('{idx: 1, data: 8'h00});
        sb.push_back('{idx: 1, data: 8'hFF});
        serve(1'b0, 1, 1'b0, 4, 9'h1FF, 4'b0000);
        serve(1'b0, 1, 1'b1, 4, 9'h000, 4'b0000);

        // Reset during bit 4 of a frame, request left pending
        req_data[31:24] = 8'hA5; req[3] = 1'b1;
        wait_ack(1'b0, 1, got);
        check("ack_seen_mid", 32'(got), 32'd1);
        check("ack_mid", 32'(ack), 32'h8);
        repeat (17) @(negedge clk);
        check("txd_bit4", 32'(txd), 32'd0);
        check("busy_bit4", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_txd", 32'(txd), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        rst = 1'b1;
        sb.push_back('{idx: 3, data: 8'hA5});
        serve(1'b0, 1, 1'b1, 4, 9'h000, 4'b0000);

        // Full-rate frame: data and other requests change during SEND
        req_data44[23:16] = 8'h96; req44[2] = 1'b1;
        sb.push_back('{idx: 2, data: 8'h96});
        serve(1'b1, 1, 1'b1, 44, 9'h100, 4'b1011);
        req44 = 4'b0000;
        @(negedge clk);
        check("ack44_idle", 32'(ack44), 32'd0);
        check("txd44_idle", 32'(txd44), 32'd1);

        e = '{idx: 0, data: 8'h00};
        if (sb.size() != 0) e = sb.pop_front();
        check("sb_drained", 32'(e.idx), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
